// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

   localparam int unsigned LOST_CNT_W  = 8;
   localparam int unsigned SEQ_STATE_W = 3;

   // seq_state encoding, also driven onto the debug/LED output
   typedef enum logic [SEQ_STATE_W-1:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_STAGGER   = 3'd1,
      ST_RUN       = 3'd2,
      ST_LOST      = 3'd3
   } seq_state_e;

   // Bits needed to hold 0..n-1; never less than 1 so every counter exists
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 in reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Metastability stage followed by the stable output stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock qualification and staggered per-core reset/enable release.
// Optional core watchdog is built when PLL_SEQ_WATCHDOG_EN is defined.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned NUM_CORES          = 4,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned STAGGER_CYCLES     = 64,
   parameter int unsigned LOSS_FILTER        = 3
`ifdef PLL_SEQ_WATCHDOG_EN
   ,
   parameter int unsigned WDT_CYCLES         = 32'd1 << 20
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pll_locked,
   input  logic                   soft_restart,
`ifdef PLL_SEQ_WATCHDOG_EN
   input  logic                   core_heartbeat,
   output logic [LOST_CNT_W-1:0]  wdt_trip_count,
`endif
   output logic [NUM_CORES-1:0]   core_rst_n,
   output logic [NUM_CORES-1:0]   core_en,
   output logic                   ready,
   output logic [LOST_CNT_W-1:0]  lock_lost_count,
   output logic [SEQ_STATE_W-1:0] seq_state
);

   localparam int unsigned STABLE_W = clog2(LOCK_STABLE_CYCLES);
   localparam int unsigned STG_W    = clog2(STAGGER_CYCLES);
   localparam int unsigned LOSS_W   = clog2(LOSS_FILTER);
   localparam int unsigned IDX_W    = clog2(NUM_CORES);

   logic                  locked_s;
   seq_state_e            state_q, state_d;
   logic [STABLE_W-1:0]   stable_q, stable_d;
   logic [STG_W-1:0]      stg_q, stg_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [LOSS_W-1:0]     loss_q, loss_d;
   logic [NUM_CORES-1:0]  core_rst_n_q, core_rst_n_d;
   logic [NUM_CORES-1:0]  core_en_q, core_en_d;
   logic                  ready_q, ready_d;
   logic [LOST_CNT_W-1:0] lost_cnt_q, lost_cnt_d;

   logic active;
   logic loss_hit;
   logic restart_req;
   logic abort;
   logic stable_done;
   logic stagger_wrap;
   logic last_core;
   logic stagger_done;

   sync_2ff u_sync_locked (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (pll_locked),
      .q_o   (locked_s)
   );

   assign active       = (state_q == ST_STAGGER) || (state_q == ST_RUN);
   assign loss_hit     = active && !locked_s && (loss_q == LOSS_W'(LOSS_FILTER - 1));
   assign abort        = active && (loss_hit || restart_req);
   assign stable_done  = (state_q == ST_WAIT_LOCK) && locked_s && !soft_restart &&
                         (stable_q == STABLE_W'(LOCK_STABLE_CYCLES - 1));
   assign stagger_wrap = (stg_q == STG_W'(STAGGER_CYCLES - 1));
   assign last_core    = (idx_q == IDX_W'(NUM_CORES - 1));
   // Last core's enable rose on the previous edge once its stagger count reads 1
   assign stagger_done = (state_q == ST_STAGGER) && last_core && (stg_q == STG_W'(1));

`ifdef PLL_SEQ_WATCHDOG_EN
   localparam int unsigned WDT_W = clog2(WDT_CYCLES);

   logic [WDT_W-1:0]      wdt_q, wdt_d;
   logic [LOST_CNT_W-1:0] wdt_trip_q, wdt_trip_d;
   logic                  wdt_trip;

   assign wdt_trip    = (state_q == ST_RUN) && !core_heartbeat &&
                        (wdt_q == WDT_W'(WDT_CYCLES - 1));
   assign restart_req = soft_restart || wdt_trip;

   // Heartbeat watchdog: counts silent RUN cycles, trips into the restart path
   always_comb begin
      wdt_d      = '0;
      wdt_trip_d = wdt_trip_q;
      if ((state_q == ST_RUN) && !core_heartbeat && !wdt_trip) begin
         wdt_d = wdt_q + WDT_W'(1);
      end
      if (wdt_trip && (wdt_trip_q != '1)) begin
         wdt_trip_d = wdt_trip_q + LOST_CNT_W'(1);
      end
   end

   // Watchdog registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wdt_q      <= '0;
         wdt_trip_q <= '0;
      end else begin
         wdt_q      <= wdt_d;
         wdt_trip_q <= wdt_trip_d;
      end
   end

   assign wdt_trip_count = wdt_trip_q;
`else
   assign restart_req = soft_restart;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_WAIT_LOCK;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT_LOCK: if (stable_done) state_d = ST_STAGGER;
         ST_STAGGER: begin
            if (abort) begin
               state_d = ST_LOST;
            end else if (stagger_done) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN:  if (abort) state_d = ST_LOST;
         default: state_d = ST_WAIT_LOCK;
      endcase
   end

   // Output and counter next values; every abort path lands with cores held in reset
   always_comb begin
      stable_d     = stable_q;
      stg_d        = stg_q;
      idx_d        = idx_q;
      loss_d       = loss_q;
      core_rst_n_d = core_rst_n_q;
      core_en_d    = core_en_q;
      ready_d      = ready_q;
      lost_cnt_d   = lost_cnt_q;

      if (loss_hit && (lost_cnt_q != '1)) begin
         lost_cnt_d = lost_cnt_q + LOST_CNT_W'(1);
      end

      case (state_q)
         ST_WAIT_LOCK: begin
            core_rst_n_d = '0;
            core_en_d    = '0;
            ready_d      = 1'b0;
            loss_d       = '0;
            stg_d        = '0;
            idx_d        = '0;
            if (!locked_s || soft_restart) begin
               stable_d = '0;
            end else if (stable_done) begin
               stable_d     = '0;
               core_rst_n_d = NUM_CORES'(1);
            end else begin
               stable_d = stable_q + STABLE_W'(1);
            end
         end
         ST_STAGGER, ST_RUN: begin
            if (abort) begin
               core_rst_n_d = '0;
               core_en_d    = '0;
               ready_d      = 1'b0;
               stable_d     = '0;
               stg_d        = '0;
               idx_d        = '0;
               loss_d       = '0;
            end else begin
               if (locked_s) begin
                  loss_d = '0;
               end else begin
                  loss_d = loss_q + LOSS_W'(1);
               end
               if (state_q == ST_STAGGER) begin
                  // Enables trail their reset release by one cycle
                  core_en_d = core_rst_n_q;
                  if (stagger_wrap) begin
                     stg_d = '0;
                     if (!last_core) begin
                        idx_d        = idx_q + IDX_W'(1);
                        core_rst_n_d = (core_rst_n_q << 1) | NUM_CORES'(1);
                     end
                  end else begin
                     stg_d = stg_q + STG_W'(1);
                  end
               end else begin
                  ready_d = 1'b1;
               end
            end
         end
         default: begin
            core_rst_n_d = '0;
            core_en_d    = '0;
            ready_d      = 1'b0;
            stable_d     = '0;
            stg_d        = '0;
            idx_d        = '0;
            loss_d       = '0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_q     <= '0;
         stg_q        <= '0;
         idx_q        <= '0;
         loss_q       <= '0;
         core_rst_n_q <= '0;
         core_en_q    <= '0;
         ready_q      <= 1'b0;
         lost_cnt_q   <= '0;
      end else begin
         stable_q     <= stable_d;
         stg_q        <= stg_d;
         idx_q        <= idx_d;
         loss_q       <= loss_d;
         core_rst_n_q <= core_rst_n_d;
         core_en_q    <= core_en_d;
         ready_q      <= ready_d;
         lost_cnt_q   <= lost_cnt_d;
      end
   end

   assign core_rst_n      = core_rst_n_q;
   assign core_en         = core_en_q;
   assign ready           = ready_q;
   assign lock_lost_count = lost_cnt_q;
   assign seq_state       = state_q;

endmodule
